packet_unpacker: RTL and testbench
==================================

// Module: packet_unpacker
// PURPOSE
//  Parametrised successor to the top-k line parser. Takes LINE_W-bit AXIS lines from the TCP RX path and
//  serialises them into WORD_W-bit words, one per cycle, through an output FIFO into the top-k datapath.
//  Adds per-word valid flags, real end-to-end backpressure and control-line decoding into an enable mask.
//  Also provides status counters.
// PARAMETERS
//  LINE_W   512  input line payload width; must be a multiple of WORD_W
//  WORD_W   32   output word width; N = LINE_W/WORD_W words per line
//  EN_W     16   enable-mask width, carried in the top EN_W bits of a control line
//  FIFO_AW  4    output FIFO address bits (depth 2**FIFO_AW)
//  CNT_W    32   status counter width
// PORTS
//  clk           in   1        single clock
//  rst_n         in   1        asynchronous, active-low reset
//  s_tdata       in   LINE_W   input line
//  s_tword_en    in   N        per-word valid; bit i covers s_tdata[i*WORD_W +: WORD_W]
//  s_tlast       in   1        last line of packet
//  s_tvalid      in   1        AXIS valid
//  s_tready      out  1        AXIS ready
//  m_tdata       out  WORD_W   output word
//  m_tlast       out  1        last word of packet
//  m_tvalid      out  1        AXIS valid
//  m_tready      in   1        AXIS ready
//  enable        out  EN_W     enable mask from the last control line
//  enable_stb    out  1        one-cycle pulse when enable is updated
//  pkt_count     out  CNT_W    packets completed (m_tlast words pushed into FIFO)
//  drop_count    out  CNT_W    lines dropped (zero valid words, not control)
//  err_lost_last out  1        one-cycle pulse: dropped line carried tlast
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - FSM goes to IDLE; FIFO is emptied.
//   - m_tvalid=0, enable=0, enable_stb=0, counters=0, err_lost_last=0.
//   - s_tready=1 from the first cycle after release.
//  Word count K
//   - K = number of contiguous 1s in s_tword_en starting at bit 0.
//   - Bits of s_tword_en above the first 0 are ignored.
//  Control line
//   - Detection: s_tdata[LINE_W-EN_W-1:0] all ones; s_tword_en and s_tlast are ignored.
//   - On accept: enable<=s_tdata[LINE_W-1 -: EN_W]; enable_stb=1 on the next cycle.
//   - No words are emitted and the FSM stays IDLE.
//   - Packet framing is unaffected. A control line between two data lines of one packet is legal.
//  FSM IDLE
//   - s_tready=1.
//   - Data line with K>0 accepted: latch line, K and tlast; idx<=0; go to UNPACK.
//   - Data line with K=0: drop_count+1; if s_tlast then err_lost_last pulses; stay IDLE.
//  FSM UNPACK
//   - When the FIFO has space, push word idx with tlast = (latched tlast && idx==K-1); idx+1.
//   - FIFO full: hold idx, push nothing.
//   - On pushing word K-1: s_tready=1 in that same cycle.
//     - If a data line is accepted then, load it with no bubble.
//     - Otherwise return to IDLE.
//   - Any other UNPACK cycle: s_tready=0.
//   - Sustained throughput is 1 word/cycle.
//  Latency and ordering
//   - Line accepted at cycle t: first word enters the FIFO at t+1.
//   - FIFO latency is at least 1 cycle. The bench does not assume a fixed latency, only order.
//  Lossless
//   - A word is never pushed when the FIFO is full.
//   - Word order and m_tlast position are preserved under any m_tready pattern.
//  Counters
//   - Wrap modulo 2**CNT_W.
//   - pkt_count and drop_count increment in the cycle of the push or drop event.
//  Simultaneous events
//   - A control line accepted in the no-bubble slot behaves as in IDLE.
//   - enable_stb may coincide with any m_* activity.
//  Reset mid-operation
//   - Partial line and FIFO contents are discarded.
//   - m_tvalid drops at rst_n assertion, without waiting for a clock edge.
// STRUCTURE
//  Shared package: LINE_W/WORD_W defaults, N, and the control-line detect mask constant.
//  Also in the package: the lead-ones count function used for K.
//  Sub-module: nukv_fifogen, DATA_SIZE=WORD_W+1 ({tlast,data}), ADDR_BITS=FIFO_AW.
//  The FIFO's s_axis_tready gates every push.
// TESTING
//  1 Data line, words 0..15, s_tword_en=FFFF, tlast=1 -> out 0..15, m_tlast only on 15, pkt_count=1.
//  2 Line A, 3 words (s_tword_en=0007, tlast=0), then full line B (tlast=1) -> 19 words, A0..A2 then B0..B15.
//    m_tlast only on the last word; s_tready high on the push cycle of A2 (no bubble).
//  3 Control line, top 16 bits=A5A5, rest ones -> enable=A5A5, one enable_stb pulse, no m_tvalid.
//  4 m_tready=0 for 40 cycles while 3 full lines are offered.
//    -> 16 words buffered, s_tready low, nothing lost; release gives 48 words in order.
//  5 s_tword_en=0000, tlast=1 -> drop_count=1, err_lost_last pulses, no output.
//    Then s_tword_en=0005 -> only word 0 is emitted.
//  6 rst_n low after the 5th word of a line -> m_tvalid=0 immediately, enable=0, counters=0.
//    s_tready=1 one cycle after release.

Source files
------------

// File: rtl/packet_unpacker_pkg.sv
// Shared definitions for the line-to-word unpacker: default widths, control-line mask,
// FSM state type and the lead-ones counter that yields the per-line word count.
package packet_unpacker_pkg;

   localparam int LINE_W_DEF  = 512;
   localparam int WORD_W_DEF  = 32;
   localparam int EN_W_DEF    = 16;
   localparam int FIFO_AW_DEF = 4;
   localparam int CNT_W_DEF   = 32;
   localparam int N_DEF       = LINE_W_DEF / WORD_W_DEF;

   // Widest word-enable vector the lead-ones helper accepts
   localparam int MAX_N = 64;

   localparam logic [LINE_W_DEF-1:0] CTRL_MASK_DEF =
      {{EN_W_DEF{1'b0}}, {(LINE_W_DEF-EN_W_DEF){1'b1}}};

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_UNPACK = 1'b1
   } state_t;

   // Count of contiguous ones from bit 0; anything above the first zero is ignored
   function automatic logic [6:0] lead_ones(input logic [MAX_N-1:0] en);
      logic [6:0] cnt;
      logic       run;
      cnt = 7'd0;
      run = 1'b1;
      for (int i = 0; i < MAX_N; i++) begin
         if (run && en[i]) begin
            cnt = cnt + 7'd1;
         end else begin
            run = 1'b0;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/nukv_fifogen.sv
// Synchronous AXIS FIFO, depth 2**ADDR_BITS, registered output valid.
// Upstream ready depends only on occupancy so a push never waits on the pop side.
module nukv_fifogen #(
   parameter int DATA_SIZE = 33,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_SIZE-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [DATA_SIZE-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready
);

   localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

   logic [DATA_SIZE-1:0] mem_r [2**ADDR_BITS];
   logic [ADDR_BITS-1:0] wr_ptr_r;
   logic [ADDR_BITS-1:0] rd_ptr_r;
   logic [ADDR_BITS:0]   count_r;
   logic [ADDR_BITS:0]   count_next_s;
   logic                 valid_r;
   logic                 push_s;
   logic                 pop_s;

   // Handshake decode and next occupancy
   always_comb begin
      push_s       = s_axis_tvalid && (count_r != DEPTH);
      pop_s        = valid_r && m_axis_tready;
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + {{ADDR_BITS{1'b0}}, 1'b1};
         2'b01:   count_next_s = count_r - {{ADDR_BITS{1'b0}}, 1'b1};
         default: count_next_s = count_r;
      endcase
   end

   // Pointer, occupancy and output-valid registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         valid_r  <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
         end
         count_r <= count_next_s;
         valid_r <= (count_next_s != {(ADDR_BITS+1){1'b0}});
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= s_axis_tdata;
      end
   end

   assign s_axis_tready = (count_r != DEPTH);
   assign m_axis_tvalid = valid_r;
   assign m_axis_tdata  = mem_r[rd_ptr_r];

endmodule

// File: rtl/packet_unpacker.sv
// Serialises wide AXIS lines into one word per cycle through an output FIFO, decodes
// control lines into an enable mask and keeps packet/drop status counters.
module packet_unpacker
   import packet_unpacker_pkg::*;
#(
   parameter int LINE_W  = LINE_W_DEF,
   parameter int WORD_W  = WORD_W_DEF,
   parameter int EN_W    = EN_W_DEF,
   parameter int FIFO_AW = FIFO_AW_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [LINE_W-1:0]          s_tdata,
   input  logic [LINE_W/WORD_W-1:0]   s_tword_en,
   input  logic                       s_tlast,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   output logic [WORD_W-1:0]          m_tdata,
   output logic                       m_tlast,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [EN_W-1:0]            enable,
   output logic                       enable_stb,
   output logic [CNT_W-1:0]           pkt_count,
   output logic [CNT_W-1:0]           drop_count,
   output logic                       err_lost_last
);

   localparam int N     = LINE_W / WORD_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int K_W   = $clog2(N + 1);
   localparam logic [LINE_W-1:0] CTRL_MASK = {{EN_W{1'b0}}, {(LINE_W-EN_W){1'b1}}};

   state_t              state_r;
   state_t              state_next_s;
   logic [LINE_W-1:0]   line_r;
   logic [K_W-1:0]      k_r;
   logic                last_r;
   logic [IDX_W-1:0]    idx_r;
   logic [EN_W-1:0]     enable_r;
   logic                enable_stb_r;
   logic [CNT_W-1:0]    pkt_count_r;
   logic [CNT_W-1:0]    drop_count_r;
   logic                err_lost_last_r;

   logic [MAX_N-1:0]    tword_ext_s;
   logic [K_W-1:0]      k_in_s;
   logic                ctrl_s;
   logic                accept_s;
   logic                load_s;
   logic                drop_s;
   logic                last_word_s;
   logic [WORD_W-1:0]   word_s;
   logic                push_last_s;
   logic                push_s;
   logic                s_tready_s;
   logic                fifo_ready_s;

   // Input line classification and current-word selection
   always_comb begin
      tword_ext_s          = '0;
      tword_ext_s[N-1:0]   = s_tword_en;
      k_in_s               = K_W'(lead_ones(tword_ext_s));
      ctrl_s               = ((s_tdata & CTRL_MASK) == CTRL_MASK);
      accept_s             = s_tvalid && s_tready_s;
      load_s               = accept_s && !ctrl_s && (k_in_s != {K_W{1'b0}});
      drop_s               = accept_s && !ctrl_s && (k_in_s == {K_W{1'b0}});
      last_word_s          = ((K_W'(idx_r) + K_W'(1)) == k_r);
      word_s               = line_r[idx_r*WORD_W +: WORD_W];
      push_last_s          = last_r && last_word_s;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state: the last push of a line may chain straight into the next line
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load_s) begin
               state_next_s = ST_UNPACK;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_UNPACK: begin
            if (push_s && last_word_s) begin
               if (load_s) begin
                  state_next_s = ST_UNPACK;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               state_next_s = ST_UNPACK;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs: push gating and upstream ready
   always_comb begin
      push_s     = 1'b0;
      s_tready_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            push_s     = 1'b0;
            s_tready_s = 1'b1;
         end
         ST_UNPACK: begin
            push_s     = fifo_ready_s;
            s_tready_s = fifo_ready_s && last_word_s;
         end
         default: begin
            push_s     = 1'b0;
            s_tready_s = 1'b0;
         end
      endcase
   end

   // Line holding register and word index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_r <= '0;
         k_r    <= '0;
         last_r <= 1'b0;
         idx_r  <= '0;
      end else begin
         if (load_s) begin
            line_r <= s_tdata;
            k_r    <= k_in_s;
            last_r <= s_tlast;
            idx_r  <= '0;
         end else if (push_s) begin
            idx_r  <= idx_r + IDX_W'(1);
         end
      end
   end

   // Enable mask, status pulses and wrapping counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_r        <= '0;
         enable_stb_r    <= 1'b0;
         pkt_count_r     <= '0;
         drop_count_r    <= '0;
         err_lost_last_r <= 1'b0;
      end else begin
         enable_stb_r    <= accept_s && ctrl_s;
         err_lost_last_r <= drop_s && s_tlast;
         if (accept_s && ctrl_s) begin
            enable_r <= s_tdata[LINE_W-1 -: EN_W];
         end
         if (drop_s) begin
            drop_count_r <= drop_count_r + CNT_W'(1);
         end
         if (push_s && push_last_s) begin
            pkt_count_r <= pkt_count_r + CNT_W'(1);
         end
      end
   end

   nukv_fifogen #(
      .DATA_SIZE (WORD_W + 1),
      .ADDR_BITS (FIFO_AW)
   ) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  ({push_last_s, word_s}),
      .s_axis_tvalid (push_s),
      .s_axis_tready (fifo_ready_s),
      .m_axis_tdata  ({m_tlast, m_tdata}),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready)
   );

   assign s_tready      = s_tready_s;
   assign enable        = enable_r;
   assign enable_stb    = enable_stb_r;
   assign pkt_count     = pkt_count_r;
   assign drop_count    = drop_count_r;
   assign err_lost_last = err_lost_last_r;

endmodule

// File: tb/tb_packet_unpacker.sv
// Directed and randomised stimulus for packet_unpacker, checked against a queue-based
// model of the expected word stream, enable mask and counters.
module tb_packet_unpacker;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [511:0]  s_tdata;
   logic [15:0]   s_tword_en;
   logic          s_tlast;
   logic          s_tvalid;
   logic          s_tready;
   logic [31:0]   m_tdata;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready;
   logic [15:0]   enable;
   logic          enable_stb;
   logic [31:0]   pkt_count;
   logic [31:0]   drop_count;
   logic          err_lost_last;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int out_words = 0;
   int stb_seen  = 0;
   int err_seen  = 0;
   int acc_cyc   = 0;
   logic hold_ready = 1'b1;
   logic rand_ready = 1'b0;

   logic [32:0] exp_q[$];
   logic [15:0] m_enable = 16'h0;
   int m_pkt  = 0;
   int m_drop = 0;
   int m_stb  = 0;
   int m_err  = 0;

   packet_unpacker dut (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(s_tdata), .s_tword_en(s_tword_en), .s_tlast(s_tlast),
      .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .enable(enable), .enable_stb(enable_stb),
      .pkt_count(pkt_count), .drop_count(drop_count), .err_lost_last(err_lost_last)
   );

   always #5 clk = ~clk;

   always @(negedge clk) cyc++;

   always @(negedge clk) begin
      #2;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Output monitor: each handshake must match the head of the expected stream
   always @(negedge clk) begin
      logic [32:0] e;
      #3;
      if (rst_n) begin
         if (m_tvalid && m_tready) begin
            out_words++;
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("word", 64'({m_tlast, m_tdata}), 64'(e));
            end
         end
         if (enable_stb) stb_seen++;
         if (err_lost_last) err_lost_seen_inc();
      end
   end

   function automatic void err_lost_seen_inc();
      err_seen++;
   endfunction

   function automatic void model_accept(input logic [511:0] d, input logic [15:0] en,
                                        input logic last);
      int k;
      if (&d[495:0]) begin
         m_enable = d[511:496];
         m_stb++;
      end else begin
         k = 0;
         while (k < 16 && en[k]) k++;
         if (k == 0) begin
            m_drop++;
            if (last) m_err++;
         end else begin
            for (int j = 0; j < k; j++)
               exp_q.push_back({last && (j == k - 1), d[j*32 +: 32]});
            if (last) m_pkt++;
         end
      end
   endfunction

   task automatic send_line(input logic [511:0] d, input logic [15:0] en, input logic last);
      int guard;
      s_tdata = d; s_tword_en = en; s_tlast = last; s_tvalid = 1'b1;
      #1;
      guard = 0;
      while (!s_tready && guard < 1000) begin
         @(negedge clk); #1; guard++;
      end
      if (!s_tready) begin
         chk("accept_timeout", 64'(s_tready), 64'd1);
         s_tvalid = 1'b0;
      end else begin
         @(posedge clk);
         acc_cyc = cyc;
         model_accept(d, en, last);
         @(negedge clk);
      end
   endtask

   task automatic idle();
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 3000) begin
         @(negedge clk); g++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [511:0] seq_line(input logic [31:0] base);
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = base + 32'(i);
      return d;
   endfunction

   function automatic logic [511:0] rand_line();
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [511:0] ctrl_line(input logic [15:0] en_val);
      logic [511:0] d;
      d = '1;
      d[511:496] = en_val;
      return d;
   endfunction

   initial begin
      int a_cyc, base, g;
      logic [511:0] d;
      logic [15:0]  en;
      logic [31:0]  r;

      s_tdata = '0; s_tword_en = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_enable", 64'(enable), 64'd0);
      chk("rst_enable_stb", 64'(enable_stb), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("rst_drop_count", 64'(drop_count), 64'd0);
      chk("rst_err", 64'(err_lost_last), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("ready_after_release", 64'(s_tready), 64'd1);

      // 1: single full line, words 0..15
      send_line(seq_line(32'd0), 16'hFFFF, 1'b1);
      idle();
      drain();
      chk("t1_pkt_count", 64'(pkt_count), 64'(m_pkt));

      // 2: short line chained into a full line without a bubble
      send_line(seq_line(32'hA000_0000), 16'h0007, 1'b0);
      a_cyc = acc_cyc;
      send_line(seq_line(32'hB000_0000), 16'hFFFF, 1'b1);
      idle();
      chk("t2_no_bubble", 64'(acc_cyc - a_cyc), 64'd3);
      drain();

      // 3: control line
      base = stb_seen;
      send_line(ctrl_line(16'hA5A5), 16'h0000, 1'b1);
      idle();
      chk("t3_stb", 64'(enable_stb), 64'd1);
      chk("t3_enable", 64'(enable), 64'hA5A5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("t3_no_output", 64'(m_tvalid), 64'd0);
      end
      chk("t3_stb_once", 64'(stb_seen - base), 64'd1);

      // 4: sink stalled while three full lines are offered
      hold_ready = 1'b0;
      @(negedge clk);
      base = out_words;
      fork
         begin
            send_line(seq_line(32'h100), 16'hFFFF, 1'b0);
            send_line(seq_line(32'h200), 16'hFFFF, 1'b0);
            send_line(seq_line(32'h300), 16'hFFFF, 1'b1);
            idle();
         end
         begin
            repeat (40) @(negedge clk);
            #1;
            chk("t4_stalled_ready", 64'(s_tready), 64'd0);
            chk("t4_valid_held", 64'(m_tvalid), 64'd1);
            chk("t4_model_queue", 64'(exp_q.size()), 64'd32);
            hold_ready = 1'b1;
         end
      join
      drain();
      chk("t4_word_total", 64'(out_words - base), 64'd48);

      // 5: empty line with tlast, then sparse enable
      send_line(rand_line(), 16'h0000, 1'b1);
      idle();
      chk("t5_err_pulse", 64'(err_lost_last), 64'd1);
      chk("t5_drop_count", 64'(drop_count), 64'(m_drop));
      base = out_words;
      send_line(seq_line(32'hC0), 16'h0005, 1'b1);
      idle();
      drain();
      chk("t5_single_word", 64'(out_words - base), 64'd1);

      // Randomised traffic with random sink backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         r = $urandom;
         case (r[1:0])
            2'd0:    en = 16'hFFFF;
            2'd1:    en = 16'((32'd1 << $urandom_range(0, 16)) - 32'd1);
            2'd2:    en = r[31:16];
            default: en = 16'(32'd1 << $urandom_range(1, 15));
         endcase
         if (r[4:2] == 3'd0) d = ctrl_line(r[31:16]);
         else d = rand_line();
         send_line(d, en, r[5]);
         if (r[7:6] == 2'd0) begin
            idle();
            @(negedge clk);
         end
      end
      idle();
      rand_ready = 1'b0;
      hold_ready = 1'b1;
      drain();
      chk("rand_pkt_count", 64'(pkt_count), 64'(m_pkt));
      chk("rand_drop_count", 64'(drop_count), 64'(m_drop));
      chk("rand_enable", 64'(enable), 64'(m_enable));
      chk("rand_stb_pulses", 64'(stb_seen), 64'(m_stb));
      chk("rand_err_pulses", 64'(err_seen), 64'(m_err));

      // 6: reset in the middle of a line
      send_line(ctrl_line(16'h1234), 16'h0000, 1'b0);
      base = out_words;
      send_line(seq_line(32'hD00), 16'hFFFF, 1'b1);
      idle();
      g = 0;
      while (out_words < base + 5 && g < 200) begin
         @(negedge clk); #4; g++;
      end
      chk("t6_five_words", 64'(out_words - base), 64'd5);
      @(posedge clk);
      #2;
      chk("t6_valid_before_reset", 64'(m_tvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_valid_async_drop", 64'(m_tvalid), 64'd0);
      chk("t6_enable", 64'(enable), 64'd0);
      chk("t6_pkt_count", 64'(pkt_count), 64'd0);
      chk("t6_drop_count", 64'(drop_count), 64'd0);
      exp_q.delete();
      m_pkt = 0; m_drop = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("t6_ready_after_release", 64'(s_tready), 64'd1);
      repeat (4) @(negedge clk);
      chk("t6_no_stale_output", 64'(m_tvalid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
